// File: rtl/mat_pow_ctrl.sv
// mat_pow_ctrl: computes R = M^n for a signed 2x2 matrix by issuing repeated
// P*M products to an external pipelined 2x2 multiplier.
// Ports:
//   clk, reset            clock and async active-high reset
//   req_valid/req_ready   request handshake; m00..m11 base matrix, exp_n exponent
//   mm_start, mm_a..mm_h  multiplier issue pulse and operands (left P, right M)
//   mm_w..mm_z, mm_done   multiplier product and result-valid
//   resp_valid/resp_ready response handshake; r00..r11 result matrix
//   sat                   an intermediate product was clamped to 16 bits
//   err                   the multiplier did not answer in time
module mat_pow_ctrl (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic signed [15:0] m00,
    input  logic signed [15:0] m01,
    input  logic signed [15:0] m10,
    input  logic signed [15:0] m11,
    input  logic        [3:0]  exp_n,
    output logic               mm_start,
    output logic signed [15:0] mm_a,
    output logic signed [15:0] mm_b,
    output logic signed [15:0] mm_c,
    output logic signed [15:0] mm_d,
    output logic signed [15:0] mm_e,
    output logic signed [15:0] mm_f,
    output logic signed [15:0] mm_g,
    output logic signed [15:0] mm_h,
    input  logic signed [31:0] mm_w,
    input  logic signed [31:0] mm_x,
    input  logic signed [31:0] mm_y,
    input  logic signed [31:0] mm_z,
    input  logic               mm_done,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic signed [31:0] r00,
    output logic signed [31:0] r01,
    output logic signed [31:0] r10,
    output logic signed [31:0] r11,
    output logic               sat,
    output logic               err
);

    localparam int unsigned DW = 16;
    localparam int unsigned PW = 32;
    localparam int unsigned NW = 4;
    localparam int unsigned WW = 3;

    // Last WAIT cycle (ISSUE + 6) in which a product is still accepted.
    localparam logic [WW-1:0] WD_LAST = WW'(6);

    localparam logic signed [PW-1:0] SAT_HI = PW'(32767);
    localparam logic signed [PW-1:0] SAT_LO = PW'(-32768);
    localparam logic [DW-1:0]        P_HI   = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        P_LO   = {1'b1, {(DW-1){1'b0}}};

    localparam logic [3:0][PW-1:0] IDENT = {PW'(1), PW'(0), PW'(0), PW'(1)};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Element order everywhere: [0]=00, [1]=01, [2]=10, [3]=11.
    logic [3:0][DW-1:0] r_m,  w_m_nxt;
    logic [3:0][DW-1:0] r_p,  w_p_nxt;
    logic [3:0][PW-1:0] r_r,  w_r_nxt;
    logic [NW-1:0]      r_rem, w_rem_nxt;
    logic [WW-1:0]      r_wd,  w_wd_nxt;
    logic               r_sat, w_sat_nxt;
    logic               r_err, w_err_nxt;
    logic               r_req_ready;
    logic               r_resp_valid;
    logic               r_mm_start;

    logic [3:0][DW-1:0] w_m_in;
    logic [3:0][PW-1:0] w_m_ext;
    logic [3:0][PW-1:0] w_prod;
    logic [3:0][DW-1:0] w_p_sat;
    logic [3:0]         w_hi;
    logic [3:0]         w_lo;

    assign w_m_in = {m11, m10, m01, m00};
    assign w_prod = {mm_z, mm_y, mm_x, mm_w};

    // Sign extension of M (n=1 result) and signed 16-bit clamp of the product.
    for (genvar g = 0; g < 4; g++) begin : g_elem
        assign w_m_ext[g] = {{(PW-DW){w_m_in[g][DW-1]}}, w_m_in[g]};
        assign w_hi[g]    = $signed(w_prod[g]) > SAT_HI;
        assign w_lo[g]    = $signed(w_prod[g]) < SAT_LO;
        assign w_p_sat[g] = w_hi[g] ? P_HI : (w_lo[g] ? P_LO : w_prod[g][DW-1:0]);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_p_nxt     = r_p;
        w_r_nxt     = r_r;
        w_rem_nxt   = r_rem;
        w_wd_nxt    = r_wd;
        w_sat_nxt   = r_sat;
        w_err_nxt   = r_err;

        case (r_state)
            IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_m_nxt   = w_m_in;
                    w_sat_nxt = 1'b0;
                    w_err_nxt = 1'b0;
                    if (exp_n == NW'(0)) begin
                        w_r_nxt     = IDENT;
                        w_state_nxt = DONE;
                    end else if (exp_n == NW'(1)) begin
                        w_r_nxt     = w_m_ext;
                        w_state_nxt = DONE;
                    end else begin
                        w_p_nxt     = w_m_in;
                        w_rem_nxt   = exp_n - NW'(1);
                        w_state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_wd_nxt    = WW'(1);
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (mm_done) begin
                    w_rem_nxt = r_rem - NW'(1);
                    // r_rem==1 means this was the last multiply.
                    if (r_rem == NW'(1)) begin
                        w_r_nxt     = w_prod;
                        w_state_nxt = DONE;
                    end else begin
                        w_p_nxt     = w_p_sat;
                        w_sat_nxt   = r_sat | (|(w_hi | w_lo));
                        w_state_nxt = ISSUE;
                    end
                end else if (r_wd == WD_LAST) begin
                    w_r_nxt     = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_wd_nxt = r_wd + WW'(1);
                end
            end
            DONE: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and registered handshake outputs, decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m          <= '0;
            r_p          <= '0;
            r_r          <= '0;
            r_rem        <= '0;
            r_wd         <= '0;
            r_sat        <= 1'b0;
            r_err        <= 1'b0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_mm_start   <= 1'b0;
        end else begin
            r_m          <= w_m_nxt;
            r_p          <= w_p_nxt;
            r_r          <= w_r_nxt;
            r_rem        <= w_rem_nxt;
            r_wd         <= w_wd_nxt;
            r_sat        <= w_sat_nxt;
            r_err        <= w_err_nxt;
            r_req_ready  <= (w_state_nxt == IDLE);
            r_resp_valid <= (w_state_nxt == DONE);
            r_mm_start   <= (w_state_nxt == ISSUE);
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign mm_start   = r_mm_start;
    assign sat        = r_sat;
    assign err        = r_err;

    // Operands come straight from P and M, which only change on acceptance or capture.
    assign mm_a = r_p[0];
    assign mm_b = r_p[1];
    assign mm_c = r_p[2];
    assign mm_d = r_p[3];
    assign mm_e = r_m[0];
    assign mm_f = r_m[1];
    assign mm_g = r_m[2];
    assign mm_h = r_m[3];

    assign r00 = r_r[0];
    assign r01 = r_r[1];
    assign r10 = r_r[2];
    assign r11 = r_r[3];

endmodule

// File: tb/tb_mat_pow_ctrl.sv
// tb_mat_pow_ctrl: self-checking bench for mat_pow_ctrl with a 3-cycle
// pipelined 2x2 multiplier model, a directed vector table, hand-written
// timeout / reset sequences and randomized requests against a matrix-power model.
module tb_mat_pow_ctrl;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic signed [15:0] m00, m01, m10, m11;
    logic        [3:0]  exp_n;
    logic               mm_start;
    logic signed [15:0] mm_a, mm_b, mm_c, mm_d, mm_e, mm_f, mm_g, mm_h;
    logic signed [31:0] mm_w, mm_x, mm_y, mm_z;
    logic               mm_done;
    logic               resp_valid;
    logic               resp_ready;
    logic signed [31:0] r00, r01, r10, r11;
    logic               sat;
    logic               err;

    int n_checks  = 0;
    int n_pass    = 0;
    int issue_cnt = 0;
    bit mm_en     = 1'b1;

    always #5 clk = ~clk;

    mat_pow_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .m00        (m00),
        .m01        (m01),
        .m10        (m10),
        .m11        (m11),
        .exp_n      (exp_n),
        .mm_start   (mm_start),
        .mm_a       (mm_a),
        .mm_b       (mm_b),
        .mm_c       (mm_c),
        .mm_d       (mm_d),
        .mm_e       (mm_e),
        .mm_f       (mm_f),
        .mm_g       (mm_g),
        .mm_h       (mm_h),
        .mm_w       (mm_w),
        .mm_x       (mm_x),
        .mm_y       (mm_y),
        .mm_z       (mm_z),
        .mm_done    (mm_done),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .r00        (r00),
        .r01        (r01),
        .r10        (r10),
        .r11        (r11),
        .sat        (sat),
        .err        (err)
    );

    // Multiplier model: start in cycle C, done in C+3. mm_en=0 makes it silent.
    logic [2:0]         mv = '0;
    logic signed [31:0] pw [3];
    logic signed [31:0] px [3];
    logic signed [31:0] py [3];
    logic signed [31:0] pz [3];

    always @(posedge clk) begin
        mv    <= {mv[1:0], mm_start & mm_en};
        pw[0] <= 32'(mm_a) * 32'(mm_e) + 32'(mm_b) * 32'(mm_g);
        px[0] <= 32'(mm_a) * 32'(mm_f) + 32'(mm_b) * 32'(mm_h);
        py[0] <= 32'(mm_c) * 32'(mm_e) + 32'(mm_d) * 32'(mm_g);
        pz[0] <= 32'(mm_c) * 32'(mm_f) + 32'(mm_d) * 32'(mm_h);
        for (int s = 1; s < 3; s++) begin
            pw[s] <= pw[s-1];
            px[s] <= px[s-1];
            py[s] <= py[s-1];
            pz[s] <= pz[s-1];
        end
    end

    assign mm_done = mv[2];
    assign mm_w    = pw[2];
    assign mm_x    = px[2];
    assign mm_y    = py[2];
    assign mm_z    = pz[2];

    always @(posedge clk) begin
        if (mm_start) issue_cnt++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Matrix power from the rules: intermediates clamped to 16 bits, last product kept at 32 bits.
    function automatic longint wrap32(input longint x);
        int y;
        y = int'(x);
        return longint'(y);
    endfunction

    function automatic longint clamp16(input longint x, inout int s);
        if (x > 32767) begin s = 1; return 32767; end
        if (x < -32768) begin s = 1; return -32768; end
        return x;
    endfunction

    function automatic void ref_pow(input int m [4], input int n, output longint r [4], output int s);
        longint p [4];
        longint t [4];
        s = 0;
        r = '{1, 0, 0, 1};
        for (int i = 0; i < 4; i++) p[i] = longint'(m[i]);
        if (n == 0) return;
        if (n == 1) begin r = p; return; end
        for (int k = 1; k < n; k++) begin
            t[0] = wrap32(p[0] * m[0] + p[1] * m[2]);
            t[1] = wrap32(p[0] * m[1] + p[1] * m[3]);
            t[2] = wrap32(p[2] * m[0] + p[3] * m[2]);
            t[3] = wrap32(p[2] * m[1] + p[3] * m[3]);
            if (k == n - 1) r = t;
            else for (int i = 0; i < 4; i++) p[i] = clamp16(t[i], s);
        end
    endfunction

    task automatic check_resp(input string tag, input longint e0, e1, e2, e3, input int es, ee);
        check({tag, " resp_valid"}, longint'(resp_valid), 1);
        check({tag, " req_ready_in_done"}, longint'(req_ready), 0);
        check({tag, " r00"}, r00, e0);
        check({tag, " r01"}, r01, e1);
        check({tag, " r10"}, r10, e2);
        check({tag, " r11"}, r11, e3);
        check({tag, " sat"}, longint'(sat), es);
        check({tag, " err"}, longint'(err), ee);
    endtask

    // One request: wait for ready, issue, measure latency, check, hold, consume.
    task automatic do_req(input string tag, input int a0, a1, a2, a3, input int n,
                          input longint e0, e1, e2, e3, input int es, ee, elat, eiss, hold);
        int guard;
        int lat;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        check({tag, " req_ready"}, longint'(req_ready), 1);
        m00       = 16'(a0);
        m01       = 16'(a1);
        m10       = 16'(a2);
        m11       = 16'(a3);
        exp_n     = 4'(n);
        req_valid = 1'b1;
        issue_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin @(negedge clk); lat++; end
        check({tag, " latency"}, lat, elat);
        check_resp(tag, e0, e1, e2, e3, es, ee);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_resp({tag, " hold"}, e0, e1, e2, e3, es, ee);
        end
        check({tag, " issues"}, issue_cnt, eiss);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, " consumed"}, longint'(resp_valid), 0);
        check({tag, " ready_after"}, longint'(req_ready), 1);
    endtask

    typedef struct {
        int     m00, m01, m10, m11, n;
        longint r00, r01, r10, r11;
        int     sat, err, lat, iss, hold;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        int     mm [4];
        int     n;
        int     rs;
        int     mode;
        longint rr [4];

        vecs[0] = '{1, 1, 1, 0, 10, 89, 55, 55, 34, 0, 0, 37, 9, 0};
        vecs[1] = '{5, 6, 7, 8, 0, 1, 0, 0, 1, 0, 0, 1, 0, 1};
        vecs[2] = '{-3, 4, -32768, 32767, 1, -3, 4, -32768, 32767, 0, 0, 1, 0, 0};
        vecs[3] = '{200, 0, 0, 200, 3, 6553400, 0, 0, 6553400, 1, 0, 9, 2, 5};
        vecs[4] = '{2, 0, 0, -1, 2, 4, 0, 0, 1, 0, 0, 5, 1, 0};
        vecs[5] = '{-1, 0, 0, -1, 15, -1, 0, 0, -1, 0, 0, 57, 14, 2};
        vecs[6] = '{-200, 0, 0, 1, 2, 40000, 0, 0, 1, 0, 0, 5, 1, 0};
        vecs[7] = '{0, -200, 200, 0, 3, 0, 6553600, -6553600, 0, 1, 0, 9, 2, 1};

        reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        m00 = '0; m01 = '0; m10 = '0; m11 = '0;
        exp_n = '0;

        repeat (3) @(negedge clk);
        check("reset req_ready", longint'(req_ready), 0);
        check("reset resp_valid", longint'(resp_valid), 0);
        check("reset mm_start", longint'(mm_start), 0);
        check("reset r00", r00, 0);
        check("reset r11", r11, 0);
        check("reset sat", longint'(sat), 0);
        check("reset err", longint'(err), 0);
        check("reset mm_a", mm_a, 0);
        check("reset mm_e", mm_e, 0);
        reset = 1'b0;
        #1;
        check("release req_ready_before_clock", longint'(req_ready), 0);
        @(negedge clk);
        check("release req_ready_after_clock", longint'(req_ready), 1);

        for (int i = 0; i < NV; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].m00, vecs[i].m01, vecs[i].m10, vecs[i].m11,
                   vecs[i].n, vecs[i].r00, vecs[i].r01, vecs[i].r10, vecs[i].r11,
                   vecs[i].sat, vecs[i].err, vecs[i].lat, vecs[i].iss, vecs[i].hold);
        end

        // Silent multiplier: watchdog ends the request at ISSUE+7.
        mm_en = 1'b0;
        do_req("timeout", 1, 2, 3, 4, 2, 0, 0, 0, 0, 0, 1, 8, 1, 1);
        mm_en = 1'b1;
        do_req("after_timeout", 1, 2, 3, 4, 2, 7, 10, 15, 22, 0, 0, 5, 1, 0);

        // Reset in the first WAIT cycle; the product of the aborted multiply lands in IDLE.
        m00 = 16'sd1; m01 = 16'sd1; m10 = 16'sd1; m11 = 16'sd0;
        exp_n     = 4'd5;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid mm_start_in_issue", longint'(mm_start), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid req_ready", longint'(req_ready), 0);
        check("rst_mid resp_valid", longint'(resp_valid), 0);
        check("rst_mid mm_start", longint'(mm_start), 0);
        check("rst_mid mm_a", mm_a, 0);
        check("rst_mid mm_e", mm_e, 0);
        check("rst_mid r00", r00, 0);
        check("rst_mid sat", longint'(sat), 0);
        check("rst_mid err", longint'(err), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst_mid idle%0d resp_valid", c), longint'(resp_valid), 0);
            check($sformatf("rst_mid idle%0d mm_start", c), longint'(mm_start), 0);
            check($sformatf("rst_mid idle%0d req_ready", c), longint'(req_ready), 1);
        end
        do_req("after_reset", 1, 1, 1, 0, 5, 8, 5, 5, 3, 0, 0, 17, 4, 0);

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 4; i++) begin
                mode = int'($urandom_range(0, 2));
                case (mode)
                    0:       mm[i] = int'($urandom_range(0, 6)) - 3;
                    1:       mm[i] = int'($urandom_range(0, 600)) - 300;
                    default: mm[i] = int'($signed(16'($urandom)));
                endcase
            end
            n = int'($urandom_range(0, 15));
            ref_pow(mm, n, rr, rs);
            do_req($sformatf("rand%0d", k), mm[0], mm[1], mm[2], mm[3], n,
                   rr[0], rr[1], rr[2], rr[3], rs, 0,
                   (n <= 1) ? 1 : 1 + 4 * (n - 1), (n <= 1) ? 0 : n - 1,
                   int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
